reg_init_bank: RTL



---
 rtl/reg_init_bank.sv | 108 ++++++++++
 1 files changed

// File: rtl/reg_init_bank.sv
// Bank of CHANNELS registers reloading port-supplied defaults on reset or on a soft sweep.
// Optional per-channel write lock is enabled by defining REG_INIT_BANK_LOCK_EN.
module reg_init_bank #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  localparam int IDXW    = $clog2(CHANNELS > 1 ? CHANNELS : 2)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] init_val,
  input  logic [CHANNELS*WIDTH-1:0] in_val,
  input  logic [CHANNELS-1:0]       wr_en,
`ifdef REG_INIT_BANK_LOCK_EN
  input  logic [CHANNELS-1:0]       lock,
`endif
  input  logic                      sweep_req,
  output logic [CHANNELS*WIDTH-1:0] out_val,
  output logic                      busy,
  output logic                      sweep_done
);

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [IDXW-1:0]   r_idx;
  logic [IDXW-1:0]   w_idx_nxt;
  logic              r_done;
  logic              w_done_nxt;
  logic [CHANNELS-1:0] w_wen;
  logic              w_sweeping;

  localparam logic [IDXW-1:0] LAST = IDXW'(CHANNELS - 1);

`ifdef REG_INIT_BANK_LOCK_EN
  assign w_wen = wr_en & ~lock;
`else
  assign w_wen = wr_en;
`endif

  assign w_sweeping = (r_state == SWEEP);
  assign busy       = w_sweeping;
  assign sweep_done = r_done;

  // Sequencer state, sweep index and done pulse registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Next-state logic: requests only accepted while idle
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_done_nxt  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (sweep_req) begin
          w_state_nxt = SWEEP;
          w_idx_nxt   = '0;
        end
      end
      SWEEP: begin
        if (r_idx == LAST) begin
          w_state_nxt = IDLE;
          w_idx_nxt   = '0;
          w_done_nxt  = 1'b1;
        end else begin
          w_idx_nxt = r_idx + 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_idx_nxt   = '0;
      end
    endcase
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [WIDTH-1:0] r_reg;
    logic             w_slot;

    assign w_slot = w_sweeping && (r_idx == IDXW'(i));
    assign out_val[i*WIDTH +: WIDTH] = r_reg;

    // Channel register: reset/sweep slot load default, else optional write
    always_ff @(posedge clk) begin
      if (rst) begin
        r_reg <= init_val[i*WIDTH +: WIDTH];
      end else if (w_slot) begin
        r_reg <= init_val[i*WIDTH +: WIDTH];
      end else if (w_wen[i]) begin
        r_reg <= in_val[i*WIDTH +: WIDTH];
      end
    end
  end

endmodule
